// File: rtl/fm_sweep_sequencer.sv
// rtl/fm_sweep_sequencer.sv - stepped carrier phase-increment sweep sequencer
// Emits one phase increment per step on the carrier-config stream, holding each step for a programmable dwell.
module fm_sweep_sequencer #(
    parameter int PINC_WIDTH  = 32,
    parameter int DWELL_WIDTH = 16,
    parameter int STEP_WIDTH  = 12
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   continuous,
    input  logic [PINC_WIDTH-1:0]  pinc_start,
    input  logic [PINC_WIDTH-1:0]  pinc_step,
    input  logic [STEP_WIDTH-1:0]  step_count,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic                   fm_enable_req,
    output logic                   fm_enable,
    output logic                   busy,
    output logic                   done,
    output logic [STEP_WIDTH-1:0]  sweep_index,
    input  logic                   M_AXIS_tready,
    output logic                   M_AXIS_tvalid,
    output logic [PINC_WIDTH-1:0]  M_AXIS_tdata
);

    typedef enum logic [1:0] {IDLE, EMIT, DWELL, DONE} state_t;

    state_t                 state_q, state_d;
    logic [PINC_WIDTH-1:0]  pinc_q, pinc_d;
    logic [PINC_WIDTH-1:0]  pinc_start_q, pinc_start_d;
    logic [PINC_WIDTH-1:0]  pinc_step_q, pinc_step_d;
    logic [STEP_WIDTH-1:0]  last_q, last_d;
    logic [STEP_WIDTH-1:0]  index_q, index_d;
    logic [DWELL_WIDTH-1:0] dwell_cfg_q, dwell_cfg_d;
    logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
    logic                   cont_q, cont_d;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            pinc_q       <= '0;
            pinc_start_q <= '0;
            pinc_step_q  <= '0;
            last_q       <= '0;
            index_q      <= '0;
            dwell_cfg_q  <= '0;
            dwell_cnt_q  <= '0;
            cont_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pinc_q       <= pinc_d;
            pinc_start_q <= pinc_start_d;
            pinc_step_q  <= pinc_step_d;
            last_q       <= last_d;
            index_q      <= index_d;
            dwell_cfg_q  <= dwell_cfg_d;
            dwell_cnt_q  <= dwell_cnt_d;
            cont_q       <= cont_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pinc_d       = pinc_q;
        pinc_start_d = pinc_start_q;
        pinc_step_d  = pinc_step_q;
        last_d       = last_q;
        index_d      = index_q;
        dwell_cfg_d  = dwell_cfg_q;
        dwell_cnt_d  = dwell_cnt_q;
        cont_d       = cont_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    pinc_start_d = pinc_start;
                    pinc_step_d  = pinc_step;
                    // A zero step count still produces one step.
                    last_d       = (step_count == '0) ? '0 : step_count - STEP_WIDTH'(1);
                    dwell_cfg_d  = dwell;
                    cont_d       = continuous;
                    pinc_d       = pinc_start;
                    index_d      = '0;
                    state_d      = EMIT;
                end
            end
            EMIT: begin
                // Abort is honoured only once the pending beat has been accepted.
                if (M_AXIS_tready) begin
                    dwell_cnt_d = dwell_cfg_q;
                    state_d     = abort ? IDLE : DWELL;
                end
            end
            DWELL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (dwell_cnt_q != '0) begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_WIDTH'(1);
                end else if (index_q < last_q) begin
                    index_d = index_q + STEP_WIDTH'(1);
                    pinc_d  = pinc_q + pinc_step_q;
                    state_d = EMIT;
                end else if (cont_q) begin
                    index_d = '0;
                    pinc_d  = pinc_start_q;
                    state_d = EMIT;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign M_AXIS_tvalid = (state_q == EMIT);
    assign M_AXIS_tdata  = pinc_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign sweep_index   = index_q;
    assign fm_enable     = fm_enable_req & ~busy;

endmodule

// File: tb/tb_fm_sweep_sequencer.sv
// tb/tb_fm_sweep_sequencer.sv - scoreboard bench for fm_sweep_sequencer
// Expected beats/done pulses come from a list-level sweep model; a negedge monitor pops and compares.
module tb_fm_sweep_sequencer;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic [31:0] pinc_start = '0;
    logic [31:0] pinc_step = '0;
    logic [11:0] step_count = '0;
    logic [15:0] dwell = '0;
    logic        fm_enable_req = 1'b0;
    logic        fm_enable;
    logic        busy;
    logic        done;
    logic [11:0] sweep_index;
    logic        M_AXIS_tready = 1'b1;
    logic        M_AXIS_tvalid;
    logic [31:0] M_AXIS_tdata;

    fm_sweep_sequencer dut (
        .aclk(aclk), .areset(areset), .start(start), .abort(abort),
        .continuous(continuous), .pinc_start(pinc_start), .pinc_step(pinc_step),
        .step_count(step_count), .dwell(dwell), .fm_enable_req(fm_enable_req),
        .fm_enable(fm_enable), .busy(busy), .done(done), .sweep_index(sweep_index),
        .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tvalid(M_AXIS_tvalid),
        .M_AXIS_tdata(M_AXIS_tdata)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        logic [31:0] data;
        logic [11:0] idx;
        int          at;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   rand_ready = 1'b0;
    bit   scramble = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Reference: a sweep is the arithmetic sequence pinc_start + i*pinc_step, one beat every dwell+2 cycles.
    task automatic push_sweep(input logic [31:0] ps, input logic [31:0] st, input int n, input int d,
                              input bit cont, input int base, input bit timed, input int reps);
        int   ne;
        exp_t e;
        ne = (n == 0) ? 1 : n;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < ne; i++) begin
                e.is_done = 1'b0;
                e.data    = ps + st * 32'(i);
                e.idx     = 12'(i);
                e.at      = timed ? base + 1 + (r * ne + i) * (d + 2) : -1;
                sbq.push_back(e);
            end
        end
        if (!cont) begin
            e.is_done = 1'b1;
            e.data    = '0;
            e.idx     = '0;
            e.at      = timed ? base + 1 + reps * ne * (d + 2) : -1;
            sbq.push_back(e);
        end
    endtask

    task automatic set_cfg(input logic [31:0] ps, input logic [31:0] st, input int n, input int d, input bit cont);
        pinc_start = ps;
        pinc_step  = st;
        step_count = 12'(n);
        dwell      = 16'(d);
        continuous = cont;
    endtask

    task automatic run_start(input logic [31:0] ps, input logic [31:0] st, input int n, input int d,
                             input bit cont, input bit timed, input int reps);
        set_cfg(ps, st, n, d, cont);
        push_sweep(ps, st, n, d, cont, cyc, timed, reps);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (!busy && sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, ok, 1'b1);
        chk({name, "_busy_low"}, busy, 1'b0);
    endtask

    // Monitor: scoreboard pop on handshake and done; stall stability; fm_enable gating.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    always @(negedge aclk) begin
        exp_t e;
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            chk("fm_enable_gate", fm_enable, fm_enable_req & ~busy);
            if (prev_stall) begin
                chk("stall_tvalid_held", M_AXIS_tvalid, 1'b1);
                chk("stall_tdata_held", M_AXIS_tdata, prev_data);
            end
            prev_stall = M_AXIS_tvalid && !M_AXIS_tready;
            prev_data  = M_AXIS_tdata;
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                if (sbq.size() == 0 || sbq[0].is_done) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got tdata %0h index %0d expected none (cycle %0d)",
                             M_AXIS_tdata, sweep_index, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("beat_tdata", M_AXIS_tdata, e.data);
                    chk("beat_index", sweep_index, e.idx);
                    if (e.at >= 0) chk("beat_cycle", cyc, e.at);
                end
            end
            if (done) begin
                if (sbq.size() == 0 || !sbq[0].is_done) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    if (e.at >= 0) chk("done_cycle", cyc, e.at);
                end
            end
        end
    end

    // Background driver: random tready, and config/request churn while busy (must be ignored).
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rand_ready) M_AXIS_tready = 1'($urandom_range(0, 1));
            if (scramble) begin
                fm_enable_req = 1'($urandom_range(0, 1));
                if (busy) begin
                    pinc_start = $urandom;
                    pinc_step  = $urandom;
                    step_count = 12'($urandom);
                    dwell      = 16'($urandom);
                    continuous = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        bit ok;
        // Reset state
        fm_enable_req = 1'b1;
        tick();
        tick();
        chk("rst_tvalid", M_AXIS_tvalid, 1'b0);
        chk("rst_tdata", M_AXIS_tdata, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_index", sweep_index, 12'h0);
        chk("rst_fm_enable_1", fm_enable, 1'b1);
        fm_enable_req = 1'b0;
        #1;
        chk("rst_fm_enable_0", fm_enable, 1'b0);
        areset = 1'b0;
        tick();

        // Basic three-step sweep
        run_start(32'd1000, 32'd10, 3, 2, 1'b0, 1'b1, 1);
        wait_idle("basic_sweep", 100);

        // Phase-increment wrap
        run_start(32'hFFFF_FFF0, 32'h20, 2, 1, 1'b0, 1'b1, 1);
        wait_idle("wrap_sweep", 100);

        // abort beats start in IDLE
        set_cfg(32'd50, 32'd1, 2, 0, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        chk("abort_start_idle", busy, 1'b0);
        tick();
        chk("abort_start_idle2", busy, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        tick();

        // Abort while stalled in EMIT: beat still delivered, then IDLE, no done
        M_AXIS_tready = 1'b0;
        set_cfg(32'd777, 32'd3, 3, 2, 1'b0);
        begin
            exp_t e;
            e.is_done = 1'b0; e.data = 32'd777; e.idx = '0; e.at = -1;
            sbq.push_back(e);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        repeat (5) tick();
        chk("abort_stall_tvalid", M_AXIS_tvalid, 1'b1);
        M_AXIS_tready = 1'b1;
        tick();
        chk("abort_after_hs_busy", busy, 1'b0);
        chk("abort_after_hs_tvalid", M_AXIS_tvalid, 1'b0);
        chk("abort_queue_empty", sbq.size(), 0);
        abort = 1'b0;
        tick();
        chk("abort_no_done", done, 1'b0);

        // Continuous sweep, stopped by abort in DWELL
        run_start(32'd5, 32'd1, 2, 1, 1'b1, 1'b1, 3);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cont_beats_seen", ok, 1'b1);
        chk("cont_still_busy", busy, 1'b1);
        abort = 1'b1;
        tick();
        chk("cont_abort_idle", busy, 1'b0);
        abort = 1'b0;
        tick();

        // FM gating and step_count=0, dwell=0
        fm_enable_req = 1'b1;
        tick();
        chk("fm_before", fm_enable, 1'b1);
        run_start(32'h1234_5678, 32'h1, 0, 0, 1'b0, 1'b1, 1);
        chk("fm_during", fm_enable, 1'b0);
        wait_idle("single_beat", 50);
        chk("fm_after", fm_enable, 1'b1);
        fm_enable_req = 1'b0;

        // Reset during DWELL of step 1, then restart
        run_start(32'd100, 32'd7, 3, 3, 1'b0, 1'b1, 1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sbq.size() <= 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached", ok, 1'b1);
        chk("rst_mid_index", sweep_index, 12'd1);
        chk("rst_mid_busy", busy, 1'b1);
        areset = 1'b1;
        #1;
        chk("rst_mid_tvalid", M_AXIS_tvalid, 1'b0);
        chk("rst_mid_tdata", M_AXIS_tdata, 32'h0);
        chk("rst_mid_busy0", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_index0", sweep_index, 12'h0);
        sbq.delete();
        tick();
        areset = 1'b0;
        repeat (3) tick();
        chk("rst_waits_idle", busy, 1'b0);
        run_start(32'd100, 32'd7, 3, 3, 1'b0, 1'b1, 1);
        wait_idle("rst_restart", 100);

        // Randomized sweeps with config churn; odd passes use random tready
        scramble = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [31:0] ps;
            logic [31:0] st;
            int          n;
            int          d;
            ps = $urandom;
            st = $urandom;
            n  = $urandom_range(0, 5);
            d  = $urandom_range(0, 4);
            rand_ready = 1'(k % 2);
            if (!rand_ready) M_AXIS_tready = 1'b1;
            tick();
            run_start(ps, st, n, d, 1'b0, !rand_ready, 1);
            wait_idle("rand_sweep", 600);
        end
        scramble = 1'b0;
        rand_ready = 1'b0;
        M_AXIS_tready = 1'b1;
        repeat (3) tick();
        chk("final_queue_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
